mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width.
REQ-002 Parameter MUL_CTRL, default 3'b111, SHALL be the ALU control code that selects a multiply.
REQ-003 clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 start_i  input  1  SHALL request an operation; sampled only in IDLE.
REQ-006 ALUCtrl_i  input  3  SHALL carry the ALU control code from the ALU control decoder.
REQ-007 data1_i  input  WIDTH  SHALL carry the multiplicand.
REQ-008 data2_i  input  WIDTH  SHALL carry the multiplier.
REQ-009 flush_i  input  1  SHALL abort an operation in progress.
REQ-010 busy_o  output  1  SHALL be high while in RUN.
REQ-011 stall_o  output  1  SHALL request a CPU pipeline/PC hold; combinational.
REQ-012 done_o  output  1  SHALL be a one-cycle pulse marking a valid result.
REQ-013 data_o  output  WIDTH  SHALL carry the low WIDTH bits of the product.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 Start is accepted in IDLE only when start_i=1 and ALUCtrl_i==MUL_CTRL; on acceptance, data1_i/data2_i, a zeroed accumulator and count=0 SHALL be latched, and the FSM SHALL go to RUN.
REQ-016 In IDLE, start_i with any other ALUCtrl_i SHALL be ignored, with no state change.
REQ-017 Each RUN cycle SHALL perform one shift-add step: if multiplier LSB=1, acc += multiplicand (mod 2^WIDTH); multiplicand <<= 1; multiplier >>= 1; count += 1.
REQ-018 RUN SHALL last exactly WIDTH cycles, with no early termination; after the step where count reaches WIDTH-1, the FSM SHALL go to DONE.
REQ-019 Latency: start accepted at edge N; done_o=1 and data_o valid during cycle N+WIDTH+1 (cycle 33 for WIDTH=32).
REQ-020 DONE SHALL last one cycle, then the FSM SHALL return to IDLE unconditionally; start_i in DONE SHALL be ignored.
REQ-021 data_o SHALL hold the last completed product until the next DONE; it SHALL NOT change during RUN.
REQ-022 stall_o SHALL be (IDLE & start_i & ALUCtrl_i==MUL_CTRL) | RUN, and low in DONE so the instruction retires with data_o.
REQ-023 start_i in RUN SHALL be ignored, with no effect on operands or count.
REQ-024 flush_i=1 in RUN SHALL return the FSM to IDLE next cycle; done_o SHALL not pulse and data_o SHALL be unchanged.
REQ-025 flush_i in IDLE SHALL block acceptance that cycle; flush_i in DONE SHALL have no effect, and done_o SHALL still pulse.
REQ-026 The result SHALL be identical for signed and unsigned operands (low half only).

Reset
REQ-027 rst_i=0 at a clock edge SHALL force IDLE, count=0, acc=0, data_o=0, done_o=0 and busy_o=0, from any state including mid-RUN.
REQ-028 While rst_i=0, stall_o SHALL be 0 regardless of start_i.
REQ-029 rst_i SHALL take priority over flush_i and start_i.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the ALU control code constants (ADD 3'b010, SUB 3'b110, AND 3'b000, OR 3'b001, MUL 3'b111).
REQ-031 The block SHALL be a single module; the shift-add datapath SHALL be inline, with no sub-module.
REQ-032 The count register SHALL be $clog2(WIDTH)+1 bits wide.

Verification
REQ-033 Scenario: ALUCtrl_i=111, data1_i=3, data2_i=5, start_i pulse at edge N -> stall_o high cycles N..N+32, done_o=1 only at N+33, data_o=15.
REQ-034 Scenario: data1_i=32'hFFFFFFFF, data2_i=2 -> data_o=32'hFFFFFFFE; data1_i=32'h80000000, data2_i=2 -> data_o=0 (wrap).
REQ-035 Scenario: start_i with ALUCtrl_i=010 -> stall_o=0, busy_o=0, state remains IDLE, data_o unchanged.
REQ-036 Scenario: flush_i at RUN cycle 10 -> IDLE next cycle, no done_o, data_o retains previous product (e.g. 15).
REQ-037 Scenario: rst_i=0 at RUN cycle 20 -> all outputs 0 next cycle; a new start 7*6 afterwards -> data_o=42 after 33 cycles.
REQ-038 Scenario: start_i held high through RUN and DONE with different operands -> first product unaffected; second operation accepted only in IDLE after DONE.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the multi-cycle shift-add multiplier sequencer:
// FSM state encoding and the ALU control codes seen by the ALU control decoder.
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluMul = 3'b111;

endpackage

// File: rtl/mul_sequencer.sv
// Sequential shift-add multiplier: one partial product per cycle for WIDTH cycles,
// holding the CPU pipeline via stall_o until the low half of the product is ready.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter logic [2:0]  MUL_CTRL = AluMul
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned     CntW      = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CntW-1:0]  count;
    logic             mul_req;

    assign mul_req  = start_i && (ALUCtrl_i == MUL_CTRL);
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // Low in DONE so the stalled instruction retires together with data_o.
    assign stall_o = rst_i && (((state == StIdle) && mul_req) || (state == StRun));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state  <= StIdle;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            data_o <= '0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done_o <= 1'b0;
                    if (mul_req && !flush_i) begin
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        acc    <= '0;
                        count  <= '0;
                        busy_o <= 1'b1;
                        state  <= StRun;
                    end
                end
                StRun: begin
                    if (flush_i) begin
                        busy_o <= 1'b0;
                        state  <= StIdle;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + CntW'(1);
                        // Result is published on the same edge as the final step.
                        if (count == LastCount) begin
                            data_o <= acc_next;
                            done_o <= 1'b1;
                            busy_o <= 1'b0;
                            state  <= StDone;
                        end
                    end
                end
                StDone: begin
                    done_o <= 1'b0;
                    state  <= StIdle;
                end
                default: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    state  <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: directed operations push expected products,
// an independent monitor pops and compares on every done_o pulse.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       alu_ctrl = AluAdd;
    logic [WIDTH-1:0] d1 = '0;
    logic [WIDTH-1:0] d2 = '0;
    logic             flush = 1'b0;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] dout;

    int checks = 0;
    int failures = 0;
    logic [WIDTH-1:0] exp_q[$];

    mul_sequencer #(.WIDTH(WIDTH), .MUL_CTRL(AluMul)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .ALUCtrl_i (alu_ctrl),
        .data1_i   (d1),
        .data2_i   (d2),
        .flush_i   (flush),
        .busy_o    (busy),
        .stall_o   (stall),
        .done_o    (done),
        .data_o    (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got data %0h expected no done", dout);
            end else begin
                chk("product", {32'd0, dout}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // Issue one multiply in IDLE and let the edge accept it.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic push);
        alu_ctrl = AluMul;
        d1 = a;
        d2 = b;
        start = 1'b1;
        #1;
        chk("stall_on_request", {63'd0, stall}, 64'd1);
        if (push) exp_q.push_back(a * b);
        tick();
        chk("busy_after_accept", {63'd0, busy}, 64'd1);
    endtask

    // Bounded wait for done; latency counted from the accepting edge.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= WIDTH + 8; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
            chk({name, "_stall_run"}, {63'd0, stall}, 64'd1);
        end
        chk({name, "_latency"}, 64'(n), 64'(WIDTH));
        chk({name, "_stall_done"}, {63'd0, stall}, 64'd0);
        chk({name, "_busy_done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        // Reset with a multiply request pending: stall must stay low.
        alu_ctrl = AluMul;
        start = 1'b1;
        #1;
        chk("reset_stall", {63'd0, stall}, 64'd0);
        tick();
        tick();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_data", {32'd0, dout}, 64'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();

        // 3 * 5
        issue(32'd3, 32'd5, 1'b1);
        start = 1'b0;
        wait_done("mul3x5");
        tick();
        chk("done_one_cycle", {63'd0, done}, 64'd0);
        chk("data_hold_15", {32'd0, dout}, 64'd15);

        // Wrap cases
        issue(32'hFFFF_FFFF, 32'd2, 1'b1);
        start = 1'b0;
        wait_done("mul_ff_x2");
        tick();
        issue(32'h8000_0000, 32'd2, 1'b1);
        start = 1'b0;
        wait_done("mul_wrap");
        tick();

        // Non-multiply ALU code is ignored
        alu_ctrl = AluAdd;
        d1 = 32'd9;
        d2 = 32'd9;
        start = 1'b1;
        #1;
        chk("add_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("add_busy", {63'd0, busy}, 64'd0);
        chk("add_data", {32'd0, dout}, 64'd0);
        start = 1'b0;

        // Flush in IDLE blocks acceptance
        alu_ctrl = AluMul;
        start = 1'b1;
        flush = 1'b1;
        tick();
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        start = 1'b0;
        flush = 1'b0;

        // Reload 15, then flush a 9*9 at RUN cycle 10
        issue(32'd3, 32'd5, 1'b1);
        start = 1'b0;
        wait_done("mul3x5_b");
        tick();
        issue(32'd9, 32'd9, 1'b0);
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        chk("flush_stall", {63'd0, stall}, 64'd0);
        chk("flush_data", {32'd0, dout}, 64'd15);
        repeat (WIDTH + 4) tick();
        chk("flush_data_later", {32'd0, dout}, 64'd15);

        // Reset mid-RUN at cycle 20, request held during reset
        issue(32'd100, 32'd3, 1'b0);
        repeat (19) tick();
        rst = 1'b0;
        #1;
        chk("midrun_reset_stall", {63'd0, stall}, 64'd0);
        tick();
        chk("midrun_reset_busy", {63'd0, busy}, 64'd0);
        chk("midrun_reset_done", {63'd0, done}, 64'd0);
        chk("midrun_reset_data", {32'd0, dout}, 64'd0);
        rst = 1'b1;
        start = 1'b0;
        tick();
        issue(32'd7, 32'd6, 1'b1);
        start = 1'b0;
        wait_done("mul7x6");
        tick();

        // Start held through RUN and DONE with changing operands
        issue(32'd4, 32'd5, 1'b1);
        d1 = 32'd100;
        d2 = 32'd100;
        exp_q.push_back(32'd10000);
        wait_done("held_first");
        tick();
        chk("held_not_in_done", {63'd0, busy}, 64'd0);
        chk("held_stall_idle", {63'd0, stall}, 64'd1);
        tick();
        chk("held_accept_idle", {63'd0, busy}, 64'd1);
        start = 1'b0;
        wait_done("held_second");

        // Flush in DONE has no effect on the pulse already presented
        tick();
        issue(32'd2, 32'd3, 1'b1);
        start = 1'b0;
        wait_done("mul2x3");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("done_flush_data", {32'd0, dout}, 64'd6);
        tick();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
